// File: rtl/apb_req_arb_if.sv
// apb_req_arb_if: bundles the two requester ports and the APB-master-side
// signals of the request arbiter.
//   master modport : arbiter view (takes requests, drives grants/completions
//                    and the decoded transaction towards the APB master).
//   slave modport  : environment view (requesters plus APB master/bus monitor).
// Parameters: WIDTH (data width), ADDRBITS (address width).
interface apb_req_arb_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRBITS = 16
);
    // requester side
    logic                req0;
    logic                req1;
    logic                wr0;
    logic                wr1;
    logic [ADDRBITS-1:0] addr0;
    logic [ADDRBITS-1:0] addr1;
    logic [WIDTH-1:0]    wdata0;
    logic [WIDTH-1:0]    wdata1;
    logic                done0;
    logic                done1;
    logic [WIDTH-1:0]    rdata0;
    logic [WIDTH-1:0]    rdata1;

    // APB master side
    logic                dec_en;
    logic                wr;
    logic [ADDRBITS-1:0] daddr;
    logic [WIDTH-1:0]    wdatadec;
    logic                psel;
    logic                penable;
    logic                pready;
    logic                wait_fifo;
    logic [WIDTH-1:0]    read_resfifo;
    logic                wenfifom;

    modport master (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        output done0, done1, rdata0, rdata1,
        output dec_en, wr, daddr, wdatadec,
        input  psel, penable, pready, wait_fifo, read_resfifo, wenfifom
    );

    modport slave (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        input  done0, done1, rdata0, rdata1,
        input  dec_en, wr, daddr, wdatadec,
        output psel, penable, pready, wait_fifo, read_resfifo, wenfifom
    );
endinterface

// File: rtl/apb_req_arb.sv
// apb_req_arb: two-requester arbiter in front of an APB master.
// Grants one requester, hands its direction/address/data to the APB master
// with a dec_en strobe, tracks the bus until the access completes, captures
// read data for the owner and returns a one-cycle doneN pulse.
// Ports:
//   apb_clk : clock, rising edge
//   reset   : asynchronous active-low reset
//   bus     : apb_req_arb_if.master (requesters + APB master signals)
// Configuration:
//   APB_ARB_FIXED_PRIO_EN defined   -> requester 0 always wins ties
//   APB_ARB_FIXED_PRIO_EN undefined -> round-robin on ties
module apb_req_arb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRBITS = 16
) (
    input  logic          apb_clk,
    input  logic          reset,
    apb_req_arb_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic                owner;       // 0: requester 0, 1: requester 1
`ifndef APB_ARB_FIXED_PRIO_EN
    logic                last_gnt;    // last requester granted
`endif
    logic                grant_c;
    logic                complete_c;
    logic                dec_en_q;
    logic                wr_q;
    logic                done0_q;
    logic                done1_q;
    logic [ADDRBITS-1:0] daddr_q;
    logic [WIDTH-1:0]    wdatadec_q;
    logic [WIDTH-1:0]    rdata0_q;
    logic [WIDTH-1:0]    rdata1_q;

    // Winner among the current requests (only used while IDLE)
    always_comb begin
        grant_c = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef APB_ARB_FIXED_PRIO_EN
            grant_c = 1'b0;
`else
            grant_c = ~last_gnt;
`endif
        end else if (bus.req1) begin
            grant_c = 1'b1;
        end
    end

    // Access phase finishing with the slave ready and room in the master FIFO
    assign complete_c = bus.psel & bus.penable & bus.pready & ~bus.wait_fifo;

    // Arbitration / transaction tracking FSM with registered outputs
    always_ff @(posedge apb_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
`ifndef APB_ARB_FIXED_PRIO_EN
            last_gnt   <= 1'b1;
`endif
            dec_en_q   <= 1'b0;
            wr_q       <= 1'b0;
            daddr_q    <= '0;
            wdatadec_q <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner      <= grant_c;
`ifndef APB_ARB_FIXED_PRIO_EN
                        last_gnt   <= grant_c;
`endif
                        wr_q       <= grant_c ? bus.wr1    : bus.wr0;
                        daddr_q    <= grant_c ? bus.addr1  : bus.addr0;
                        wdatadec_q <= grant_c ? bus.wdata1 : bus.wdata0;
                        dec_en_q   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // master SETUP phase seen: it has taken the transaction
                    if (bus.psel && !bus.penable) begin
                        dec_en_q <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.wenfifom && !wr_q) begin
                        if (owner) rdata1_q <= bus.read_resfifo;
                        else       rdata0_q <= bus.read_resfifo;
                    end
                    if (complete_c) begin
                        done0_q <= ~owner;
                        done1_q <= owner;
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dec_en   = dec_en_q;
    assign bus.wr       = wr_q;
    assign bus.daddr    = daddr_q;
    assign bus.wdatadec = wdatadec_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;

endmodule

// File: doc/apb_req_arb.md
APB_REQ_ARB -- requirements
Module: apb_req_arb

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, data width; ADDRBITS, 16, address width.
REQ-002 apb_clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 req0/req1  input  1  requester N transaction request; held high until doneN.
REQ-005 wr0/wr1  input  1  requester N direction (1 write, 0 read); stable while reqN high.
REQ-006 addr0/addr1  input  ADDRBITS  requester N address; stable while reqN high.
REQ-007 wdata0/wdata1  input  WIDTH  requester N write data; stable while reqN high.
REQ-008 done0/done1  output  1  one-cycle completion pulse to requester N.
REQ-009 rdata0/rdata1  output  WIDTH  read data for requester N; valid with doneN, held until next completion for N.
REQ-010 dec_en  output  1  transaction enable to APB master.
REQ-011 wr, daddr, wdatadec  output  1/ADDRBITS/WIDTH  granted requester's direction, address and data to APB master.
REQ-012 psel, penable, pready, wait_fifo  input  1 each  monitored APB bus and master FIFO-full signals.
REQ-013 read_resfifo  input  WIDTH; wenfifom  input  1  master read response and its valid strobe.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, BUSY, DONE; all outputs registered or decoded from state and registers only.
REQ-015 IDLE: any reqN high -> select owner, latch wrN/addrN/wdataN into wr/daddr/wdatadec, go ISSUE next edge; else stay.
REQ-016 Arbitration SHALL be round-robin: single request wins; both requesting -> requester not granted last; pointer updates on grant.
REQ-017 ISSUE: dec_en=1; leave to BUSY on cycle where psel=1 and penable=0 (master SETUP observed).
REQ-018 BUSY: dec_en=0; wr/daddr/wdatadec held; completion = psel & penable & pready & !wait_fifo -> DONE next edge.
REQ-019 In BUSY, wenfifom=1 on a read SHALL capture read_resfifo into owner's rdata register.
REQ-020 DONE: doneN=1 for owner for exactly one cycle, then IDLE; non-owner reqN ignored in DONE.
REQ-021 Requester SHALL drop reqN in the DONE cycle; reqN still high on return to IDLE is a new request.
REQ-022 Minimum latency: reqN rising in IDLE -> dec_en 1 cycle later -> doneN 5 cycles after request with pready=1, wait_fifo=0.
REQ-023 pready=0 or wait_fifo=1 SHALL extend BUSY indefinitely; no timeout.
REQ-024 Request changes from non-owner during ISSUE/BUSY SHALL not affect owner outputs.
REQ-025 Outside ISSUE, dec_en SHALL be 0; done0 and done1 SHALL never be high together.

Reset
REQ-026 reset low SHALL force IDLE, dec_en=0, wr=0, daddr=0, wdatadec=0, done0/done1=0, rdata0/rdata1=0, pointer = requester 1 last-granted (requester 0 wins first tie).
REQ-027 Reset mid-transaction SHALL abandon it with no doneN pulse; first grant after release follows REQ-026 pointer.

Configuration
REQ-028 Macro APB_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win ties, pointer unused; undefined: round-robin per REQ-016.

Verification
REQ-029 req0=1 wr0=1 addr0=16'h0010 wdata0=32'hA5A5_0001, pready=1 -> dec_en one cycle, daddr=16'h0010, wdatadec=32'hA5A5_0001 in ACCESS, done0 pulse 5 cycles after req0.
REQ-030 req1=1 read addr1=16'h0020, slave returns 32'hDEAD_BEEF with wenfifom -> done1 pulse, rdata1=32'hDEAD_BEEF held afterwards.
REQ-031 req0 and req1 asserted together, re-asserted after each done (round-robin) -> grant order 0,1,0,1; with APB_ARB_FIXED_PRIO_EN -> 0,0,0.
REQ-032 pready held 0 for 10 ACCESS cycles then wait_fifo=1 for 3 -> stays BUSY, doneN 1 cycle after both clear, no second dec_en.
REQ-033 reset asserted in BUSY -> all outputs zero at once, no done pulse; after release req1 alone granted normally.
